scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Sequencer for the bouncing-position datapath: owns the 3-bit position counter and left/right direction state, steps them at a programmable rate, holds at each end for a programmable dwell, and drives a one-hot LED bus. Sits between control registers (en/clr/speed/dwell) and the LED output stage. Supersedes free-running direction logic: direction flips are sequenced here together with the position update.

## Interface
- `N_POS`, 8, number of positions; `pos` range 0..N_POS-1
- `POS_W`, 3, width of `pos` (= clog2(N_POS))
- `DIV_W`, 16, width of `speed_div`
- `DWELL_W`, 4, width of `dwell`

- `clk`  in  1  system clock, rising edge
- `arst_n`  in  1  asynchronous active-low reset
- `en`  in  1  run request; level-sensitive
- `clr`  in  1  synchronous clear to home position
- `speed_div`  in  DIV_W  tick period minus one, in clk cycles
- `dwell`  in  DWELL_W  extra tick periods held at each end
- `pos`  out  POS_W  current position
- `dir`  out  1  1 = RIGHT (incrementing), 0 = LEFT
- `leds`  out  N_POS  one-hot, `leds[pos]` = 1
- `step`  out  1  one-cycle pulse, high in the cycle a new `pos` is first visible
- `busy`  out  1  state != IDLE

## Operation
- Reset values: state IDLE, `pos`=0, `dir`=1, `leds`=1, `step`=0, `busy`=0, prescaler and dwell counters 0.
- States: IDLE, RUN, DWELL.
- IDLE: prescaler held at 0. `en`=1 → RUN.
- RUN: prescaler counts; tick when count >= `speed_div`, then count returns to 0. On tick: `pos` ← `pos`+1 if `dir`=1, else `pos`−1; `step`=1. If the new `pos` is N_POS−1 (with `dir`=1) or 0 (with `dir`=0), `dir` inverts on the same edge; if `dwell` != 0, load dwell counter with `dwell` and go to DWELL.
- DWELL: prescaler counts as in RUN; each tick decrements dwell counter; the tick that takes it from 1 to 0 returns to RUN without moving `pos`. Net: `pos` stays at an end for (1+`dwell`) tick periods.
- `en`=0 in RUN or DWELL → IDLE on next edge; `pos`, `dir` frozen; dwell counter cleared. Re-enable resumes from frozen `pos`/`dir`.
- `clr`=1: highest priority over `en` and tick; next edge: IDLE, `pos`=0, `dir`=1, counters 0, `step`=0.
- `speed_div` read every cycle (>= comparison makes a decrease mid-count tick immediately); `dwell` sampled only on DWELL entry.
- `pos` never leaves 0..N_POS−1; no wrap-around.

## Timing
- All outputs registered except `leds` and `busy` (combinational decode of `pos`/state).
- `en` sampled high at edge k → `busy`=1 after k; first tick at edge k+1+`speed_div`.
- `speed_div`=0: one step per cycle.
- `arst_n` low at any time, including mid-DWELL: immediate return to reset values.

## Structure
- Package `scan_pkg`: state enum (IDLE/RUN/DWELL), `DIR_RIGHT`=1, `DIR_LEFT`=0, default N_POS/DIV_W/DWELL_W constants.
- Sub-module `tick_prescaler` (clk, arst_n, run, div → tick); remainder in `scan_sequencer`.

## Test plan
- Reset, `speed_div`=0, `dwell`=0, `en`=1 → `pos` 1..7 on consecutive edges, `dir`=0 in the same cycle `pos`=7, then 6..0, `dir`=1 when `pos`=0; `step` high every cycle.
- `speed_div`=3 → `step` exactly every 4 cycles; `leds` = 8'b0000_0001 << `pos` at all times.
- `dwell`=2, `speed_div`=3 → `pos`=7 held 12 cycles, then 6; same at `pos`=0.
- `en` dropped at `pos`=4, `dir`=1 for 10 cycles → `busy`=0, `pos`=4 frozen, no `step`; re-enable → next step to 5.
- `clr` and `en` both high with `pos`=5, `dir`=0 → next edge `pos`=0, `dir`=1, `busy`=0; `arst_n` pulsed mid-DWELL → reset values immediately.
- `speed_div` 100 → 2 while count = 50 → tick on next cycle, then period 3.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// scan_sequencer_pkg: shared constants, direction encoding and state type for the scan sequencer
package scan_pkg;
  localparam int N_POS = 8;
  localparam int POS_W = $clog2(N_POS);
  localparam int DIV_W = 16;
  localparam int DWELL_W = 4;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT = 1'b0;
  typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;
endpackage

// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if: control-register inputs and LED-stage outputs of the scan sequencer
interface scan_sequencer_if;
  import scan_pkg::*;
  logic en;
  logic clr;
  logic [DIV_W-1:0] speed_div;
  logic [DWELL_W-1:0] dwell;
  logic [POS_W-1:0] pos;
  logic dir;
  logic [N_POS-1:0] leds;
  logic step;
  logic busy;
  modport master(output en, clr, speed_div, dwell, input pos, dir, leds, step, busy);
  modport slave(input en, clr, speed_div, dwell, output pos, dir, leds, step, busy);
endinterface

// File: rtl/scan_sequencer_tick_prescaler.sv
// tick_prescaler: counts while run is high and fires tick when the count reaches div
module tick_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  // >= lets a lowered div take effect immediately instead of waiting for wrap
  always_comb begin
    tick = run && (cnt_q >= div);
    cnt_d = (!run || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a bouncing position at a programmable rate with dwell at each end
module scan_sequencer
  import scan_pkg::*;
(
  input  logic      clk,
  input  logic      arst_n,
  scan_sequencer_if.slave bus
);
  state_t state_q;
  logic [POS_W-1:0] pos_q, pos_d;
  logic dir_q, step_q, tick, run, at_end;
  logic [DWELL_W-1:0] dwell_q;
  assign run = (state_q != IDLE) && bus.en && !bus.clr;
  tick_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk(clk), .arst_n(arst_n), .run(run), .div(bus.speed_div), .tick(tick)
  );
  always_comb begin
    pos_d = (dir_q == DIR_RIGHT) ? pos_q + 1'b1 : pos_q - 1'b1;
    at_end = (dir_q == DIR_RIGHT) ? (pos_d == POS_W'(N_POS - 1)) : (pos_d == '0);
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state_q <= IDLE;
      pos_q <= '0;
      dir_q <= DIR_RIGHT;
      dwell_q <= '0;
      step_q <= 1'b0;
    end else if (bus.clr) begin
      state_q <= IDLE;
      pos_q <= '0;
      dir_q <= DIR_RIGHT;
      dwell_q <= '0;
      step_q <= 1'b0;
    end else if (!bus.en) begin
      state_q <= IDLE;
      dwell_q <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= (state_q == RUN) && tick;
      case (state_q)
        IDLE: state_q <= RUN;
        RUN: if (tick) begin
          pos_q <= pos_d;
          if (at_end) begin
            dir_q <= ~dir_q;
            if (bus.dwell != '0) begin
              dwell_q <= bus.dwell;
              state_q <= DWELL;
            end
          end
        end
        DWELL: if (tick) begin
          dwell_q <= dwell_q - 1'b1;
          if (dwell_q == DWELL_W'(1)) state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.pos = pos_q;
  assign bus.dir = dir_q;
  assign bus.step = step_q;
  assign bus.leds = N_POS'(1) << pos_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed vector table plus hand-written corner sequences for scan_sequencer
module tb_scan_sequencer;
  import scan_pkg::*;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  scan_sequencer_if bus();
  scan_sequencer dut (.clk(clk), .arst_n(arst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic en; logic clr; logic [15:0] sd; logic [3:0] dw;
    int pos; logic dir; logic step; logic busy;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input int p, input logic d, input logic s, input logic b);
    logic [7:0] el;
    el = 8'd1 << p;
    chk({name, ".pos"}, int'(bus.pos), p);
    chk({name, ".dir"}, int'(bus.dir), int'(d));
    chk({name, ".step"}, int'(bus.step), int'(s));
    chk({name, ".busy"}, int'(bus.busy), int'(b));
    chk({name, ".leds"}, int'(bus.leds), int'(el));
  endtask

  task automatic add(input logic en, input logic clr, input int sd, input int dw,
                     input int p, input logic d, input logic s, input logic b);
    vec_t v;
    v.en = en; v.clr = clr; v.sd = 16'(sd); v.dw = 4'(dw);
    v.pos = p; v.dir = d; v.step = s; v.busy = b;
    vq.push_back(v);
  endtask

  task automatic wait_pos(input string name, input int p, input bit use_dir, input logic d);
    int n;
    n = 0;
    while (!(int'(bus.pos) == p && (!use_dir || bus.dir == d)) && n < 200) begin
      tick();
      n++;
    end
    chk({name, ".reached"}, int'(n < 200), 1);
  endtask

  task automatic measure_hold(input string name, input int p, input int nxt, input int exp_len);
    int len;
    wait_pos(name, p, 1'b0, 1'b0);
    len = 0;
    while (int'(bus.pos) == p && len < 100) begin
      tick();
      len++;
    end
    chk({name, ".hold"}, len, exp_len);
    chk({name, ".next"}, int'(bus.pos), nxt);
  endtask

  initial begin
    bus.en = 1'b0; bus.clr = 1'b0; bus.speed_div = '0; bus.dwell = '0;
    #12;
    chk_all("reset", 0, 1'b1, 1'b0, 1'b0);
    arst_n = 1'b1;
    tick();
    chk_all("idle", 0, 1'b1, 1'b0, 1'b0);

    // full sweep at one step per cycle, direction flips in the cycle each end is reached
    add(1, 0, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 1, 1, 1, 1);
    add(1, 0, 0, 0, 2, 1, 1, 1);
    add(1, 0, 0, 0, 3, 1, 1, 1);
    add(1, 0, 0, 0, 4, 1, 1, 1);
    add(1, 0, 0, 0, 5, 1, 1, 1);
    add(1, 0, 0, 0, 6, 1, 1, 1);
    add(1, 0, 0, 0, 7, 0, 1, 1);
    add(1, 0, 0, 0, 6, 0, 1, 1);
    add(1, 0, 0, 0, 5, 0, 1, 1);
    add(1, 0, 0, 0, 4, 0, 1, 1);
    add(1, 0, 0, 0, 3, 0, 1, 1);
    add(1, 0, 0, 0, 2, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 1, 1, 1, 1);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 3, 0, 0, 1, 0, 1);
    foreach (vq[i]) begin
      bus.en = vq[i].en; bus.clr = vq[i].clr;
      bus.speed_div = vq[i].sd; bus.dwell = vq[i].dw;
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].pos, vq[i].dir, vq[i].step, vq[i].busy);
    end

    for (int i = 1; i <= 16; i++) begin
      tick();
      chk_all($sformatf("div3_c%0d", i), i / 4, 1'b1, (i % 4) == 0, 1'b1);
    end

    bus.dwell = 4'd2;
    measure_hold("dwell_hi", 7, 6, 12);
    measure_hold("dwell_lo", 0, 1, 12);

    bus.speed_div = '0; bus.dwell = '0;
    wait_pos("to4", 4, 1'b1, 1'b1);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all($sformatf("frozen%0d", i), 4, 1'b1, 1'b0, 1'b0);
    end
    bus.en = 1'b1;
    tick();
    chk_all("resume0", 4, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("resume1", 5, 1'b1, 1'b1, 1'b1);

    wait_pos("to5L", 5, 1'b1, 1'b0);
    bus.clr = 1'b1;
    tick();
    chk_all("clr", 0, 1'b1, 1'b0, 1'b0);
    bus.clr = 1'b0;

    bus.speed_div = 16'd3; bus.dwell = 4'd3;
    wait_pos("to7", 7, 1'b0, 1'b0);
    chk("pre_arst.step", int'(bus.step), 1);
    arst_n = 1'b0;
    #1;
    chk_all("arst", 0, 1'b1, 1'b0, 1'b0);
    bus.speed_div = 16'd100; bus.dwell = '0;
    #1 arst_n = 1'b1;
    tick();
    chk_all("sd100_start", 0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) tick();
    chk_all("sd100_c50", 0, 1'b1, 1'b0, 1'b1);
    bus.speed_div = 16'd2;
    tick();
    chk_all("sd2_now", 1, 1'b1, 1'b1, 1'b1);
    tick();
    chk_all("sd2_g1", 1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("sd2_g2", 1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("sd2_next", 2, 1'b1, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
